// File: rtl/pmem_line_adaptor_if.sv
// Bus bundle between the cache miss path and the 64-bit burst memory port.
// Signal directions are named from the adaptor's point of view.
interface pmem_line_adaptor_if #(
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned BURST_W = 64,
    parameter int unsigned ADDR_W  = 32
);
    logic [ADDR_W-1:0]  address_i;
    logic               read_i;
    logic               write_i;
    logic [LINE_W-1:0]  line_i;
    logic [LINE_W-1:0]  line_o;
    logic               resp_o;
    logic [ADDR_W-1:0]  address_o;
    logic               read_o;
    logic               write_o;
    logic [BURST_W-1:0] burst_o;
    logic [BURST_W-1:0] burst_i;
    logic               resp_i;

    modport slave (
        input  address_i, read_i, write_i, line_i, burst_i, resp_i,
        output line_o, resp_o, address_o, read_o, write_o, burst_o
    );

    modport master (
        output address_i, read_i, write_i, line_i, burst_i, resp_i,
        input  line_o, resp_o, address_o, read_o, write_o, burst_o
    );
endinterface

// File: rtl/pmem_line_adaptor.sv
// Converts single line fill/writeback requests into BEATS-long memory bursts.
// One transaction in flight; beats always ordered lowest address first.
module pmem_line_adaptor #(
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned BURST_W = 64,
    parameter int unsigned BEATS   = LINE_W / BURST_W,
    parameter int unsigned ADDR_W  = 32
) (
    input logic                   clk,
    input logic                   rst,
    pmem_line_adaptor_if.slave    bus_io
);
    localparam int unsigned CNT_W = $clog2(BEATS);
    localparam int unsigned OFF_W = $clog2(LINE_W / 8);

    typedef enum logic [1:0] {StIdle, StRdBurst, StWrBurst, StDone} state_e;

    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               beat_cnt_q, beat_cnt_d;
    logic [BEATS-1:0][BURST_W-1:0]  fill_q, fill_d;
    logic [BEATS-1:0][BURST_W-1:0]  wb_q, wb_d;
    logic [ADDR_W-1:0]              addr_q, addr_d;
    logic                           last_beat;
    logic [ADDR_W-1:0]              addr_aligned;
    logic                           unused_addr_lsbs;

    assign last_beat        = (beat_cnt_q == CNT_W'(BEATS - 1));
    assign addr_aligned     = {bus_io.address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign unused_addr_lsbs = ^bus_io.address_i[OFF_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            beat_cnt_q <= '0;
            fill_q     <= '0;
            wb_q       <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            fill_q     <= fill_d;
            wb_q       <= wb_d;
            addr_q     <= addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        fill_d     = fill_q;
        wb_d       = wb_q;
        addr_d     = addr_q;
        unique case (state_q)
            StIdle: begin
                // Writeback wins so the victim line leaves before the fill lands.
                if (bus_io.write_i) begin
                    addr_d     = addr_aligned;
                    wb_d       = bus_io.line_i;
                    beat_cnt_d = '0;
                    state_d    = StWrBurst;
                end else if (bus_io.read_i) begin
                    addr_d     = addr_aligned;
                    beat_cnt_d = '0;
                    state_d    = StRdBurst;
                end
            end
            StRdBurst: begin
                if (bus_io.resp_i) begin
                    fill_d[beat_cnt_q] = bus_io.burst_i;
                    beat_cnt_d         = beat_cnt_q + CNT_W'(1);
                    if (last_beat) state_d = StDone;
                end
            end
            StWrBurst: begin
                if (bus_io.resp_i) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (last_beat) state_d = StDone;
                end
            end
            StDone: begin
                beat_cnt_d = '0;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus_io.line_o    = fill_q;
    assign bus_io.address_o = addr_q;
    assign bus_io.read_o    = (state_q == StRdBurst);
    assign bus_io.write_o   = (state_q == StWrBurst);
    assign bus_io.resp_o    = (state_q == StDone);
    assign bus_io.burst_o   = wb_q[beat_cnt_q];
endmodule

// File: tb/tb_pmem_line_adaptor.sv
// Self-checking bench: table of line transactions plus hand-written corner sequences,
// with a scoreboard queue of expected line_o values popped on each resp_o.
module tb_pmem_line_adaptor;
    localparam int unsigned LINE_W  = 256;
    localparam int unsigned BURST_W = 64;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned BEATS   = 4;
    localparam int unsigned NVEC    = 5;

    typedef logic [BEATS-1:0][BURST_W-1:0] line_t;
    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        line_t             data;
        logic [15:0]       mask;
        logic [ADDR_W-1:0] exp_addr;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    pmem_line_adaptor_if #(.LINE_W(LINE_W), .BURST_W(BURST_W), .ADDR_W(ADDR_W)) bus ();

    pmem_line_adaptor #(
        .LINE_W  (LINE_W),
        .BURST_W (BURST_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    line_t exp_q[$];
    line_t last_line;
    vec_t  vecs[NVEC];

    task automatic chk(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input logic wr, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < 8) begin
            tick();
            n++;
            if (bus.read_o || bus.write_o) begin
                ok = 1'b1;
                break;
            end
        end
        chk("req_latency", n, 1);
        chk("req_write_o", bus.write_o, wr);
        chk("req_read_o", bus.read_o, !wr);
    endtask

    task automatic run_txn(input logic wr, input logic rd, input logic [ADDR_W-1:0] addr,
                           input line_t data, input logic [15:0] mask,
                           input logic [ADDR_W-1:0] exp_addr, input bit keep_rd);
        bit    ok;
        int    beat;
        int    k;
        logic  r;
        line_t exp_line;
        chk("pre_req_idle", bus.read_o | bus.write_o, 0);
        bus.address_i = addr;
        bus.write_i   = wr;
        bus.read_i    = rd;
        if (wr) begin
            bus.line_i = data;
            exp_q.push_back(last_line);
        end else begin
            exp_q.push_back(data);
            last_line = data;
        end
        wait_req(wr, ok);
        if (!ok) begin
            bus.write_i = 1'b0;
            bus.read_i  = 1'b0;
            void'(exp_q.pop_back());
            return;
        end
        beat = 0;
        k    = 0;
        while (beat < BEATS && k < 32) begin
            r = (k < 16) ? mask[k] : 1'b1;
            chk("busy_resp_o", bus.resp_o, 0);
            chk("addr_hold", bus.address_o, exp_addr);
            chk(wr ? "write_o_hold" : "read_o_hold", wr ? bus.write_o : bus.read_o, 1);
            if (wr) chk("burst_o", bus.burst_o, data[beat]);
            bus.resp_i  = r;
            bus.burst_i = r ? data[beat] : ~data[beat];
            tick();
            if (r) beat++;
            k++;
        end
        bus.resp_i  = 1'b0;
        bus.burst_i = '0;
        chk("resp_pulse", bus.resp_o, 1);
        chk("req_dropped", bus.read_o | bus.write_o, 0);
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 1, 0);
        end else begin
            exp_line = exp_q.pop_front();
            if (bus.resp_o) chk("line_o", bus.line_o, exp_line);
        end
        bus.write_i = 1'b0;
        if (!keep_rd) bus.read_i = 1'b0;
        tick();
        chk("resp_one_cycle", bus.resp_o, 0);
        chk("line_hold", bus.line_o, last_line);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit    ok;
        line_t d;

        vecs[0] = '{1'b0, 32'h0000_1234,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                    16'hFFFF, 32'h0000_1220};
        vecs[1] = '{1'b1, 32'h0000_2FFF,
                    {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
                     64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000},
                    16'hFFFF, 32'h0000_2FE0};
        // 1,0,0,1,1,0,1 LSB first
        vecs[2] = '{1'b0, 32'h8000_0040,
                    {64'hA0A1_A2A3_A4A5_A6A7, 64'hB0B1_B2B3_B4B5_B6B7,
                     64'hC0C1_C2C3_C4C5_C6C7, 64'hE0E1_E2E3_E4E5_E6E7},
                    16'h0059, 32'h8000_0040};
        vecs[3] = '{1'b1, 32'hFFFF_FFFF,
                    {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                     64'h5555_AAAA_5555_AAAA, 64'hDEAD_BEEF_CAFE_F00D},
                    16'h0055, 32'hFFFF_FFE0};
        vecs[4] = '{1'b0, 32'h0000_001F,
                    {64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0,
                     64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE},
                    16'hFFFF, 32'h0000_0000};

        rst           = 1'b0;
        bus.address_i = '0;
        bus.read_i    = 1'b0;
        bus.write_i   = 1'b0;
        bus.line_i    = '0;
        bus.burst_i   = '0;
        bus.resp_i    = 1'b0;
        last_line     = '0;
        tick();
        tick();
        chk("rst_line_o", bus.line_o, 0);
        chk("rst_addr_o", bus.address_o, 0);
        chk("rst_ctrl", {bus.read_o, bus.write_o, bus.resp_o}, 0);
        chk("rst_burst_o", bus.burst_o, 0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < int'(NVEC); i++) begin
            run_txn(vecs[i].wr, !vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].mask,
                    vecs[i].exp_addr, 1'b0);
        end

        // Simultaneous read and write: writeback first, fill follows on held read_i.
        d = {64'h5A5A_0000_0000_0003, 64'h5A5A_0000_0000_0002,
             64'h5A5A_0000_0000_0001, 64'h5A5A_0000_0000_0000};
        run_txn(1'b1, 1'b1, 32'h0000_0100, d, 16'hFFFF, 32'h0000_0100, 1'b1);
        d = {64'h6666_0000_0000_0003, 64'h6666_0000_0000_0002,
             64'h6666_0000_0000_0001, 64'h6666_0000_0000_0000};
        run_txn(1'b0, 1'b1, 32'h0000_0100, d, 16'hFFFF, 32'h0000_0100, 1'b0);

        // Spurious memory strobes while idle.
        for (int i = 0; i < 3; i++) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = {$urandom, $urandom};
            tick();
            chk("idle_resp_o", bus.resp_o, 0);
            chk("idle_req", bus.read_o | bus.write_o, 0);
            chk("idle_line_o", bus.line_o, last_line);
        end
        bus.resp_i  = 1'b0;
        bus.burst_i = '0;
        tick();

        // Reset after two beats of a read.
        bus.address_i = 32'h0000_0440;
        bus.read_i    = 1'b1;
        wait_req(1'b0, ok);
        for (int i = 0; i < 2; i++) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = 64'hBAD0_0000_0000_0000 | 64'(i);
            tick();
        end
        bus.resp_i = 1'b0;
        bus.read_i = 1'b0;
        rst        = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("midrst_line_o", bus.line_o, 0);
            chk("midrst_addr_o", bus.address_o, 0);
            chk("midrst_ctrl", {bus.read_o, bus.write_o, bus.resp_o}, 0);
            chk("midrst_burst_o", bus.burst_o, 0);
        end
        rst       = 1'b1;
        last_line = '0;
        tick();
        chk("postrst_resp_o", bus.resp_o, 0);
        d = {64'h7777_0000_0000_0003, 64'h7777_0000_0000_0002,
             64'h7777_0000_0000_0001, 64'h7777_0000_0000_0000};
        run_txn(1'b0, 1'b1, 32'h0000_0455, d, 16'hFFFF, 32'h0000_0440, 1'b0);

        chk("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
